// File: rtl/fifo_share_pkg.sv
// Shared definitions for the FIFO-sharing arbiter: FSM states and the id width helper.
package fifo_share_pkg;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority first-one search: the first set bit of elig_i at or after ptr_i, wrapping.
module rr_pick
   import fifo_share_pkg::*;
#(
   parameter int N   = 4,
   parameter int IdW = id_width(N)
) (
   input  logic [N-1:0]   elig_i,
   input  logic [IdW-1:0] ptr_i,
   output logic [IdW-1:0] idx_o,
   output logic           found_o
);

   int j;

   // Scan from the far end back toward ptr so the closest hit is written last.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      j       = 0;
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(ptr_i) + i;
         if (j >= N) j = j - N;
         if (elig_i[IdW'(j)]) begin
            idx_o   = IdW'(j);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_share_arbiter.sv
// Credit-limited round-robin arbiter feeding a shared FIFO; holds a stalled grant until accepted.
module fifo_share_arbiter
   import fifo_share_pkg::*;
#(
   parameter int  NumReq      = 4,
   parameter int  Depth       = 8,
   parameter int  Quota       = 4,
   parameter bit  SameCycleRW = 1'b1,
   parameter type type_t      = logic,
   localparam int IdW         = id_width(NumReq),
   localparam int TotW        = $clog2(Depth + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  type_t             data_i [NumReq],
   input  logic [NumReq-1:0] valid_i,
   output logic [NumReq-1:0] ready_o,
   output type_t             data_o,
   output logic [IdW-1:0]    id_o,
   output logic              valid_o,
   input  logic              ready_i,
   input  logic              pop_i,
   input  logic [IdW-1:0]    pop_id_i,
   output logic [TotW-1:0]   total_o
);

   localparam int CntW = $clog2(Quota + 1);
   localparam logic [CntW-1:0] QuotaC = CntW'(Quota);
   localparam logic [TotW-1:0] DepthC = TotW'(Depth);
   localparam logic [IdW-1:0]  LastId = IdW'(NumReq - 1);

   state_e            state_q, state_d;
   logic [IdW-1:0]    ptr_q, ptr_d, lock_q, lock_d;
   logic [CntW-1:0]   cnt_q [NumReq];
   logic [CntW-1:0]   cnt_d [NumReq];
   logic [NumReq-1:0] elig;
   logic [IdW-1:0]    pick, sel;
   logic              found, room, push;
   logic [TotW-1:0]   total;

   always_comb begin
      total = '0;
      for (int k = 0; k < NumReq; k++) total = total + TotW'(cnt_q[k]);
   end
   assign total_o = total;

   // A full FIFO still has room when the consumer frees a slot this very cycle.
   assign room = (total < DepthC) || (SameCycleRW && (total == DepthC) && pop_i);

   always_comb begin
      elig = '0;
      for (int k = 0; k < NumReq; k++) elig[k] = valid_i[k] && (cnt_q[k] < QuotaC) && room;
   end

   rr_pick #(.N(NumReq), .IdW(IdW)) u_pick (
      .elig_i  (elig),
      .ptr_i   (ptr_q),
      .idx_o   (pick),
      .found_o (found)
   );

   always_comb begin
      sel     = (state_q == LOCKED) ? lock_q : pick;
      valid_o = !rst_i && !flush_i && ((state_q == LOCKED) || found);
      id_o    = sel;
      data_o  = data_i[sel];
      push    = valid_o && ready_i;
      ready_o = '0;
      if (push) ready_o[sel] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      ptr_d   = ptr_q;
      for (int k = 0; k < NumReq; k++) cnt_d[k] = cnt_q[k];
      case (state_q)
         IDLE:    if (found && !ready_i) begin
                     state_d = LOCKED;
                     lock_d  = pick;
                  end
         LOCKED:  if (ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (push) ptr_d = (sel == LastId) ? '0 : sel + 1'b1;
      // A push and a pop to the same requester cancel out.
      for (int k = 0; k < NumReq; k++) begin
         if ((push && sel == IdW'(k)) && !(pop_i && pop_id_i == IdW'(k)))
            cnt_d[k] = cnt_q[k] + 1'b1;
         else if (!(push && sel == IdW'(k)) && (pop_i && pop_id_i == IdW'(k)) && cnt_q[k] != '0)
            cnt_d[k] = cnt_q[k] - 1'b1;
      end
      if (flush_i) begin
         state_d = IDLE;
         ptr_d   = '0;
         for (int k = 0; k < NumReq; k++) cnt_d[k] = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         lock_q  <= '0;
         for (int k = 0; k < NumReq; k++) cnt_q[k] <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
         for (int k = 0; k < NumReq; k++) cnt_q[k] <= cnt_d[k];
      end
   end

   logic           stall_q;
   logic [IdW-1:0] stall_id_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) stall_q <= 1'b0;
      else       stall_q <= valid_o && !ready_i;
      stall_id_q <= id_o;
      if (!rst_i && !flush_i) begin
         if (stall_q)
            assert (valid_o && id_o == stall_id_q)
               else $error("stalled grant withdrawn or changed");
         if (pop_i) begin
            assert (int'(pop_id_i) < NumReq)
               else $warning("pop_id_i out of range, ignored");
            assert (int'(pop_id_i) >= NumReq || cnt_q[pop_id_i] != '0 || (push && sel == pop_id_i))
               else $warning("pop with zero credit, saturated");
         end
      end
   end

endmodule

// File: tb/tb_fifo_share_arbiter.sv
// Directed bench: scoreboard of expected grants plus direct occupancy checks on three configurations.
module tb_fifo_share_arbiter;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, flush, rdy, pop;
   logic [1:0] pop_id;
   logic [3:0] vin;
   logic [7:0] din [4];

   logic [3:0] rdyo_a, rdyo_b, rdyo_c;
   logic [7:0] dout_a, dout_b, dout_c;
   logic [1:0] id_a, id_b, id_c;
   logic       vld_a, vld_b, vld_c;
   logic [3:0] tot_a, tot_b, tot_c;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   fifo_share_arbiter #(.NumReq(4), .Depth(8), .Quota(2), .SameCycleRW(1'b1), .type_t(logic [7:0])) u_a (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(din), .valid_i(vin), .ready_o(rdyo_a),
      .data_o(dout_a), .id_o(id_a), .valid_o(vld_a), .ready_i(rdy), .pop_i(pop), .pop_id_i(pop_id),
      .total_o(tot_a));

   fifo_share_arbiter #(.NumReq(4), .Depth(8), .Quota(4), .SameCycleRW(1'b1), .type_t(logic [7:0])) u_b (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(din), .valid_i(vin), .ready_o(rdyo_b),
      .data_o(dout_b), .id_o(id_b), .valid_o(vld_b), .ready_i(rdy), .pop_i(pop), .pop_id_i(pop_id),
      .total_o(tot_b));

   fifo_share_arbiter #(.NumReq(4), .Depth(8), .Quota(4), .SameCycleRW(1'b0), .type_t(logic [7:0])) u_c (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(din), .valid_i(vin), .ready_o(rdyo_c),
      .data_o(dout_c), .id_o(id_c), .valid_o(vld_c), .ready_i(rdy), .pop_i(pop), .pop_id_i(pop_id),
      .total_o(tot_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle on u_a: expected valid/id, ready_o, and scoreboard of accepted payloads.
   task automatic cycle(input logic ev, input int eid);
      logic [3:0] er;
      exp_t       got, want;
      er = (ev && rdy) ? (4'b0001 << eid) : 4'b0000;
      if (ev && rdy) sb.push_back('{id: 2'(eid), data: din[eid]});
      #2;
      chk("valid_o", 32'(vld_a), 32'(ev));
      if (ev) chk("id_o", 32'(id_a), 32'(eid));
      chk("ready_o", 32'(rdyo_a), 32'(er));
      if (vld_a && rdy) begin
         chk("sb_depth", 32'(sb.size()), 32'd1);
         if (sb.size() > 0) begin
            want = sb.pop_front();
            got  = '{id: id_a, data: dout_a};
            chk("sb_id", 32'(got.id), 32'(want.id));
            chk("sb_data", 32'(got.data), 32'(want.data));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 4; k++) din[k] = 8'(8'h11 * (k + 1));
      rst = 1'b1; flush = 1'b0; vin = 4'hF; rdy = 1'b1; pop = 1'b0; pop_id = 2'd0;

      // Reset holds outputs quiet even with every requester asking.
      cycle(1'b0, 0);
      cycle(1'b0, 0);
      rst = 1'b0;
      chk("reset_total", 32'(tot_a), 32'd0);

      // Round robin with each push popped a cycle later.
      for (int i = 0; i < 8; i++) begin
         pop = (i > 0); pop_id = 2'((i + 3) % 4);
         if (i > 0) chk("rr_total", 32'(tot_a), 32'd1);
         cycle(1'b1, i % 4);
      end
      vin = 4'h0; pop = 1'b1; pop_id = 2'd3;
      cycle(1'b0, 0);
      pop = 1'b0;
      chk("rr_drain", 32'(tot_a), 32'd0);

      // Quota of two on requester 1, released by one pop.
      vin = 4'b0010;
      cycle(1'b1, 1);
      cycle(1'b1, 1);
      pop = 1'b1; pop_id = 2'd1;
      cycle(1'b0, 0);
      pop = 1'b0;
      cycle(1'b1, 1);
      chk("quota_total", 32'(tot_a), 32'd2);
      vin = 4'h0; pop = 1'b1; pop_id = 2'd1;
      cycle(1'b0, 0);
      cycle(1'b0, 0);
      pop = 1'b0;
      chk("quota_drain", 32'(tot_a), 32'd0);

      // Stalled grant on req2 held while req0 joins; then wrap to req0.
      vin = 4'b0100; rdy = 1'b0;
      cycle(1'b1, 2);
      vin = 4'b0101;
      cycle(1'b1, 2);
      cycle(1'b1, 2);
      rdy = 1'b1;
      cycle(1'b1, 2);
      cycle(1'b1, 0);
      vin = 4'h0; pop = 1'b1; pop_id = 2'd2;
      cycle(1'b0, 0);
      pop_id = 2'd0;
      cycle(1'b0, 0);
      pop = 1'b0;

      // Flush while locked with five entries outstanding.
      vin = 4'hF;
      for (int i = 1; i <= 5; i++) cycle(1'b1, i % 4);
      rdy = 1'b0;
      cycle(1'b1, 2);
      chk("flush_pre_total", 32'(tot_a), 32'd5);
      flush = 1'b1;
      cycle(1'b0, 0);
      flush = 1'b0;
      chk("flush_total", 32'(tot_a), 32'd0);
      cycle(1'b1, 0);
      vin = 4'h0; rdy = 1'b1;
      cycle(1'b1, 0);
      chk("lock_ignores_valid", 32'(tot_a), 32'd1);

      // Pop against a zero credit saturates.
      pop = 1'b1; pop_id = 2'd3;
      cycle(1'b0, 0);
      chk("underflow_total", 32'(tot_a), 32'd1);
      pop_id = 2'd0;
      cycle(1'b0, 0);
      pop = 1'b0;
      chk("underflow_drain", 32'(tot_a), 32'd0);

      // Reset in the middle of a lock drops it.
      vin = 4'b0010; rdy = 1'b0;
      cycle(1'b1, 1);
      rst = 1'b1; vin = 4'hF; rdy = 1'b1;
      cycle(1'b0, 0);
      rst = 1'b0; vin = 4'b0001; rdy = 1'b0;
      cycle(1'b1, 0);
      chk("rst_lock_total", 32'(tot_a), 32'd0);
      vin = 4'h0; rdy = 1'b1;
      cycle(1'b1, 0);

      // Fill the Quota=4 instances to Depth, then push while popping.
      vin = 4'b1110;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk);
         #1;
      end
      #2;
      chk("b_full", 32'(tot_b), 32'd8);
      chk("c_full", 32'(tot_c), 32'd8);
      vin = 4'b0001; pop = 1'b1; pop_id = 2'd1;
      #2;
      chk("b_samecycle_valid", 32'(vld_b), 32'd1);
      chk("b_samecycle_id", 32'(id_b), 32'd0);
      chk("b_samecycle_ready", 32'(rdyo_b), 32'b0001);
      chk("b_samecycle_data", 32'(dout_b), 32'(din[0]));
      chk("c_refuse_valid", 32'(vld_c), 32'd0);
      chk("c_refuse_ready", 32'(rdyo_c), 32'd0);
      @(posedge clk);
      #1;
      pop = 1'b0; vin = 4'h0;
      #2;
      chk("b_total_stays", 32'(tot_b), 32'd8);
      chk("c_total_drops", 32'(tot_c), 32'd7);

      chk("sb_left", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
